// File: rtl/tone_square_gen.sv
// Gated square-wave tone generator: plays a latched half-period with glitch-free
// period changes, always ends a note on a falling edge, and gates the output by a 3-bit PWM volume.
module tone_square_gen #(
  parameter int PERIOD_W = 19,
  parameter int MIN_HALF = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] half_period,
  input  logic                note_on,
  input  logic [2:0]          volume,
  output logic                speaker,
  output logic                active,
  output logic [PERIOD_W-1:0] cur_half
);

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_e;

  state_e              state_q, state_d;
  logic                wave_q, wave_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] cur_half_q, cur_half_d;
  logic [2:0]          pwm_cnt_q;
  logic                speaker_q;

  logic                valid;
  logic                start;
  logic                expiry;
  logic                gate;
  logic [PERIOD_W-1:0] reload_half;

  // Half-periods below MIN_HALF are never latched, so cnt reloads can't underflow.
  assign valid       = (half_period >= PERIOD_W'(MIN_HALF));
  assign start       = note_on & valid;
  assign expiry      = (state_q != IDLE) && (cnt_q == '0);
  assign reload_half = valid ? half_period : cur_half_q;
  assign gate        = (volume == 3'd7) || (pwm_cnt_q < volume);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d    = state_q;
    wave_d     = wave_q;
    cnt_d      = cnt_q;
    cur_half_d = cur_half_q;

    unique case (state_q)
      IDLE: begin
        wave_d = 1'b0;
        cnt_d  = '0;
        if (start) begin
          state_d    = PLAY;
          wave_d     = 1'b1;
          cur_half_d = half_period;
          cnt_d      = half_period - PERIOD_W'(1);
        end
      end
      PLAY, RELEASE: begin
        if (expiry && (state_q == RELEASE) && !start && wave_q) begin
          // A releasing note finishes only after a complete high half.
          state_d = IDLE;
          wave_d  = 1'b0;
          cnt_d   = '0;
        end else if (expiry) begin
          state_d    = start ? PLAY : RELEASE;
          wave_d     = ~wave_q;
          cur_half_d = reload_half;
          cnt_d      = reload_half - PERIOD_W'(1);
        end else begin
          state_d = start ? PLAY : RELEASE;
          cnt_d   = cnt_q - PERIOD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wave_q     <= 1'b0;
      cnt_q      <= '0;
      cur_half_q <= '0;
      pwm_cnt_q  <= 3'd0;
      speaker_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wave_q     <= wave_d;
      cnt_q      <= cnt_d;
      cur_half_q <= cur_half_d;
      pwm_cnt_q  <= pwm_cnt_q + 3'd1;
      speaker_q  <= wave_q & gate & (state_q != IDLE);
    end
  end

  assign active   = (state_q != IDLE);
  assign speaker  = speaker_q;
  assign cur_half = cur_half_q;

endmodule

// File: tb/tb_tone_square_gen.sv
// Self-checking bench for tone_square_gen: directed scenarios plus randomized
// traffic compared against a "cycles left in the current half" reference model.
module tb_tone_square_gen;

  localparam int PW = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] half_period = '0;
  logic          note_on = 1'b0;
  logic [2:0]    volume = 3'd7;
  logic          speaker;
  logic          active;
  logic [PW-1:0] cur_half;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: sounding flag, releasing flag, output level, cycles left
  // in the current half (including the present one), latched half length.
  logic          m_on, m_rel, m_level, m_spk;
  int            m_left;
  int            m_pwm;
  logic [PW-1:0] m_len;

  tone_square_gen #(.PERIOD_W(PW), .MIN_HALF(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .half_period(half_period),
    .note_on    (note_on),
    .volume     (volume),
    .speaker    (speaker),
    .active     (active),
    .cur_half   (cur_half)
  );

  always #10 clk = ~clk;

  task automatic model_edge();
    logic spk_n, valid, start;
    if (reset) begin
      m_on = 0; m_rel = 0; m_level = 0; m_spk = 0; m_left = 0; m_pwm = 0; m_len = '0;
    end else begin
      spk_n = m_level && m_on && ((volume == 3'd7) || (m_pwm < int'(volume)));
      m_pwm = (m_pwm + 1) % 8;
      valid = (half_period >= 2);
      start = note_on && valid;
      if (!m_on) begin
        if (start) begin
          m_on = 1; m_rel = 0; m_level = 1; m_len = half_period; m_left = int'(half_period);
        end
      end else if (m_left == 1) begin
        if (m_rel && !start && m_level) begin
          m_on = 0; m_rel = 0; m_level = 0; m_left = 0;
        end else begin
          m_level = !m_level;
          if (valid) m_len = half_period;
          m_left = int'(m_len);
          m_rel  = !start;
        end
      end else begin
        m_left = m_left - 1;
        m_rel  = !start;
      end
      m_spk = spk_n;
    end
  endtask

  // Advance one clock edge, update the model, and land on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    note_on = 1'b1; half_period = 4; volume = 3'd7;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({speaker, active, cur_half} !== {1'b0, 1'b0, {PW{1'b0}}})
        $display("FAIL reset cyc%0d: got spk=%b act=%b half=%0d want 0/0/0", i, speaker, active, cur_half);
      else n_pass++;
    end
    reset = 1'b0;
    note_on = 1'b0;
    tick();
  endtask

  task automatic test_basic_tone();
    logic [15:0] cap = '0;
    do_reset();
    volume = 3'd7; half_period = 4; note_on = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      cap = {cap[14:0], speaker};
      n_total++;
      if ({speaker, active, cur_half} !== {m_spk, m_on, m_len})
        $display("FAIL basic cyc%0d: got %b/%b/%0d want %b/%b/%0d", i, speaker, active, cur_half, m_spk, m_on, m_len);
      else n_pass++;
    end
    n_total++;
    if (cap !== 16'hF0F0 || cur_half !== 19'd4)
      $display("FAIL basic_pattern: got %h half=%0d want f0f0 half=4", cap, cur_half);
    else n_pass++;
    note_on = 1'b0;
  endtask

  task automatic test_period_change();
    logic [15:0] cap = '0;
    do_reset();
    volume = 3'd7; half_period = 4; note_on = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) half_period = 6;
      cap = {cap[14:0], speaker};
      n_total++;
      if ({speaker, active, cur_half} !== {m_spk, m_on, m_len})
        $display("FAIL period_chg cyc%0d: got %b/%b/%0d want %b/%b/%0d", i, speaker, active, cur_half, m_spk, m_on, m_len);
      else n_pass++;
    end
    n_total++;
    if (cap !== 16'hF03F)
      $display("FAIL period_chg_pattern: got %h want f03f", cap);
    else n_pass++;
    note_on = 1'b0;
  endtask

  task automatic test_release();
    do_reset();
    volume = 3'd7; half_period = 5; note_on = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 5) note_on = 1'b0;
      n_total++;
      if ({speaker, active, cur_half} !== {m_spk, m_on, m_len})
        $display("FAIL release cyc%0d: got %b/%b/%0d want %b/%b/%0d", i, speaker, active, cur_half, m_spk, m_on, m_len);
      else n_pass++;
      if (i == 14 || i == 20) begin
        n_total++;
        if (active !== (i == 14))
          $display("FAIL release_active cyc%0d: got %b want %b", i, active, (i == 14));
        else n_pass++;
      end
    end
    n_total++;
    if (speaker !== 1'b0)
      $display("FAIL release_end_speaker: got %b want 0", speaker);
    else n_pass++;
  endtask

  task automatic test_volume();
    logic seen_high = 1'b0;
    do_reset();
    volume = 3'd2; half_period = 16; note_on = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      n_total++;
      if ({speaker, active, cur_half} !== {m_spk, m_on, m_len})
        $display("FAIL volume2 cyc%0d: got %b/%b/%0d want %b/%b/%0d", i, speaker, active, cur_half, m_spk, m_on, m_len);
      else n_pass++;
    end
    volume = 3'd0;
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (speaker) seen_high = 1'b1;
    end
    n_total++;
    if (seen_high !== 1'b0 || active !== 1'b1)
      $display("FAIL volume0: speaker_seen_high=%b active=%b want 0/1", seen_high, active);
    else n_pass++;
    note_on = 1'b0; volume = 3'd7;
  endtask

  task automatic test_invalid_half();
    do_reset();
    half_period = 1; note_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if (active !== 1'b0 || cur_half !== '0)
        $display("FAIL invalid_start cyc%0d: active=%b half=%0d want 0/0", i, active, cur_half);
      else n_pass++;
    end
    half_period = 6;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 3) half_period = 0;
      n_total++;
      if ({speaker, active, cur_half} !== {m_spk, m_on, m_len})
        $display("FAIL invalid_zero cyc%0d: got %b/%b/%0d want %b/%b/%0d", i, speaker, active, cur_half, m_spk, m_on, m_len);
      else n_pass++;
    end
    n_total++;
    if (cur_half !== 19'd6)
      $display("FAIL invalid_keep_half: got %0d want 6", cur_half);
    else n_pass++;
    note_on = 1'b0;
  endtask

  task automatic test_reset_mid_note();
    do_reset();
    volume = 3'd7; half_period = 4; note_on = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if ({speaker, active, cur_half} !== {1'b0, 1'b0, {PW{1'b0}}})
      $display("FAIL reset_mid: got %b/%b/%0d want 0/0/0", speaker, active, cur_half);
    else n_pass++;
    tick();
    n_total++;
    if (active !== 1'b1 || cur_half !== 19'd4)
      $display("FAIL reset_restart: active=%b half=%0d want 1/4", active, cur_half);
    else n_pass++;
    note_on = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) note_on = ~note_on;
      if ($urandom_range(0, 9) == 0) half_period = PW'($urandom_range(0, 9));
      if ($urandom_range(0, 40) == 0) volume = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 400) == 0);
      tick();
      n_total++;
      if ({speaker, active, cur_half} !== {m_spk, m_on, m_len})
        $display("FAIL random cyc%0d: got %b/%b/%0d want %b/%b/%0d", i, speaker, active, cur_half, m_spk, m_on, m_len);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    m_on = 0; m_rel = 0; m_level = 0; m_spk = 0; m_left = 0; m_pwm = 0; m_len = '0;
    test_reset();
    test_basic_tone();
    test_period_change();
    test_release();
    test_volume();
    test_invalid_half();
    test_reset_mid_note();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tone_square_gen.md
TONE_SQUARE_GEN -- requirements
Module: tone_square_gen

Interface
REQ-001 Parameter PERIOD_W, default 19, width of half-period input and counter.
REQ-002 Parameter MIN_HALF, default 2, smallest half-period (in clk cycles) accepted as a valid tone.
REQ-003 clk  input  1  system clock (50 MHz board clock); all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 half_period  input  PERIOD_W  requested tone half-period in clk cycles, produced by the upstream note player.
REQ-006 note_on  input  1  level; high while a note is requested.
REQ-007 volume  input  3  loudness level 0..7.
REQ-008 speaker  output  1  gated square wave to the speaker pin.
REQ-009 active  output  1  high in PLAY or RELEASE.
REQ-010 cur_half  output  PERIOD_W  half-period currently in use (latched).

Function
REQ-011 States: IDLE, PLAY, RELEASE; internal regs: wave (1), cnt (PERIOD_W), cur_half, pwm_cnt (3).
REQ-012 valid = (half_period >= MIN_HALF); start = note_on & valid.
REQ-013 IDLE: wave=0, cnt held 0; on start -> PLAY next cycle with wave=1, cur_half=half_period, cnt=half_period-1.
REQ-014 Expiry = (cnt==0) in PLAY or RELEASE; otherwise cnt decrements by 1 each cycle.
REQ-015 On expiry: wave toggles; cur_half reloads from half_period if valid, else retained; cnt = (new cur_half)-1.
REQ-016 Period changes take effect only at expiry (glitch-free; no half-cycle ever truncated or extended mid-way).
REQ-017 PLAY with !start -> RELEASE next cycle; no phase or counter change.
REQ-018 RELEASE with start -> PLAY next cycle, phase and cnt preserved.
REQ-019 RELEASE expiry with wave==1: wave->0, state->IDLE, cnt->0 (note always ends on falling edge, full high half completed).
REQ-020 RELEASE expiry with wave==0: wave->1, reload per REQ-015, remain RELEASE.
REQ-021 Simultaneous expiry and note_on rise in RELEASE: PLAY takes priority; wave toggles per REQ-015, no return to IDLE.
REQ-022 pwm_cnt free-runs +1 per cycle, wraps 7->0; gate = (volume==7) | (pwm_cnt < volume).
REQ-023 speaker = wave & gate & active, registered (one cycle after wave/gate); volume 0 forces speaker=0.
REQ-024 active = (state != IDLE), combinational from state register.
REQ-025 half_period of 0 or 1 never loaded into cur_half; no underflow of cnt.

Reset
REQ-026 reset high at a clk edge: state=IDLE, wave=0, cnt=0, cur_half=0, pwm_cnt=0, speaker=0, active=0, overriding all other inputs.
REQ-027 reset mid-note: tone stops immediately; after release of reset, a held note_on with valid half_period restarts from REQ-013 one cycle later.

Verification
REQ-028 volume=7, half_period=4, note_on held: after start, wave pattern 1111 0000 repeating, speaker same delayed 1 cycle, cur_half=4.
REQ-029 half_period 4->6 mid high-half: current high-half stays 4 cycles, next low-half 6 cycles; no glitch on speaker.
REQ-030 note_on dropped 1 cycle into low half (half_period=5): low half completes, one full 5-cycle high half, then IDLE, active=0, speaker=0.
REQ-031 volume=2, half_period=16: during wave high, speaker high exactly on pwm_cnt 0,1 of each 8-cycle window; volume=0 -> speaker constant 0.
REQ-032 note_on with half_period=1: stays IDLE, active=0; in PLAY changing half_period to 0 keeps cur_half unchanged.
REQ-033 reset asserted for 1 cycle in PLAY with wave=1: next cycle all outputs 0; note_on still high -> PLAY again one cycle after reset deasserts.
